// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants and types for the SRAM-backed first-word-fall-through FIFO.
// The prefetch buffer has its own small pointer type because its depth is not a power of two.
package fifo_package;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 16;
  localparam int OBUF_DEPTH = 3;
  localparam int CNT_WIDTH  = ADDR_WIDTH + 2;

  typedef logic [1:0]            ob_ptr_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH:0]   mem_cnt_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  // The obuf pointers wrap at OBUF_DEPTH, so a plain binary increment is not enough.
  function automatic ob_ptr_t ob_ptr_inc(input ob_ptr_t p);
    return (p == ob_ptr_t'(OBUF_DEPTH - 1)) ? ob_ptr_t'(0) : p + ob_ptr_t'(1);
  endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop streaming handshake bundle between the FIFO controller and its producer/consumer.
// A word moves on a clock edge where valid & ready are both high; valid must not wait for ready.
interface sram_fifo_ctrl_if;
  import fifo_package::*;

  logic  push_valid_i;
  logic  push_ready_o;
  data_t push_data_i;
  logic  pop_valid_o;
  logic  pop_ready_i;
  data_t pop_data_o;

  modport slave (
    input  push_valid_i, push_data_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pop_data_o
  );

  modport master (
    output push_valid_i, push_data_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pop_data_o
  );

endinterface

// File: rtl/fifo_obuf.sv
// Three-entry prefetch register FIFO; the head word is presented straight from a register.
// The controller never writes when full nor reads when empty, so no overflow guard lives here.
module fifo_obuf
  import fifo_package::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  data_t      wr_data,
  input  logic       rd_en,
  output data_t      rd_data,
  output logic [1:0] count
);

  ob_ptr_t head;
  ob_ptr_t tail;
  data_t   mem [OBUF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= ob_ptr_inc(tail);
      if (rd_en) head <= ob_ptr_inc(head);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= wr_data;
  end

  assign rd_data = mem[head];

endmodule

// File: rtl/sram.sv
// Single-port synchronous SRAM: write on we_i, registered read data one cycle after the address.
// The array has no reset; contents survive a controller reset.
module sram
  import fifo_package::*;
(
  input  logic  clk,
  input  addr_t addr_i,
  input  data_t wdata_i,
  input  logic  we_i,
  output data_t rdata_o
);

  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Turns a single-port SRAM into a first-word-fall-through FIFO, arbitrating the port between
// pushes and prefetch reads and hiding the read latency behind a small output buffer.
module sram_fifo_ctrl
  import fifo_package::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  sram_fifo_ctrl_if.slave         fifo,
  output addr_t                   sram_addr_o,
  output data_t                   sram_wdata_o,
  output logic                    sram_we_o,
  input  data_t                   sram_rdata_i,
  output cnt_t                    count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  addr_t      wr_ptr;
  addr_t      rd_ptr;
  mem_cnt_t   mem_cnt;
  logic       rd_inflight;
  logic       wr_turn;
  logic [1:0] ob_cnt;

  logic rd_want;
  logic rd_sched;
  logic push_ready;
  logic push_fire;
  logic pop_fire;

  // Only registers feed rd_want, so push_ready never loops back through push_valid.
  assign rd_want    = (mem_cnt != '0) &&
                      (({1'b0, ob_cnt} + {2'b00, rd_inflight}) < 3'(OBUF_DEPTH));
  assign full_o     = (mem_cnt == mem_cnt_t'(DEPTH));
  assign push_ready = !full_o && !(rd_want && !wr_turn);
  assign rd_sched   = rd_want && !(wr_turn && fifo.push_valid_i);
  assign push_fire  = fifo.push_valid_i && push_ready;
  assign pop_fire   = fifo.pop_valid_o && fifo.pop_ready_i;

  assign fifo.push_ready_o = push_ready;
  assign fifo.pop_valid_o  = (ob_cnt != 2'd0);

  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = rd_ptr;
    sram_wdata_o = '0;
    if (push_fire) begin
      sram_we_o    = 1'b1;
      sram_addr_o  = wr_ptr;
      sram_wdata_o = fifo.push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
      wr_turn     <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + addr_t'(1);
      if (rd_sched)  rd_ptr <= rd_ptr + addr_t'(1);
      case ({push_fire, rd_sched})
        2'b10:   mem_cnt <= mem_cnt + mem_cnt_t'(1);
        2'b01:   mem_cnt <= mem_cnt - mem_cnt_t'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      rd_inflight <= rd_sched;
      // A read this cycle hands the next contended cycle to the writer, and vice versa.
      wr_turn     <= rd_sched;
    end
  end

  fifo_obuf u_obuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rd_inflight),
    .wr_data (sram_rdata_i),
    .rd_en   (pop_fire),
    .rd_data (fifo.pop_data_o),
    .count   (ob_cnt)
  );

  assign count_o = cnt_t'(mem_cnt) + cnt_t'(rd_inflight) + cnt_t'(ob_cnt);
  assign empty_o = (count_o == '0);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl plus sram: directed scenarios and random traffic, with a
// queue-based reference of the FIFO contents checked on every cycle.
module tb_sram_fifo_ctrl;
  import fifo_package::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_fifo_ctrl_if bus();

  addr_t sram_addr;
  data_t sram_wdata;
  data_t sram_rdata;
  logic  sram_we;
  cnt_t  count;
  logic  full;
  logic  empty;

  sram_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo         (bus),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_we_o    (sram_we),
    .sram_rdata_i (sram_rdata),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  sram u_sram (
    .clk     (clk),
    .addr_i  (sram_addr),
    .wdata_i (sram_wdata),
    .we_i    (sram_we),
    .rdata_o (sram_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  int wr_addr_m = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      wr_addr_m = 0;
    end else begin
      check_val("count", 32'(count), 32'(exp_q.size()));
      check_val("empty", 32'(empty), 32'(exp_q.size() == 0));
      if (full) check_val("full_blocks_push", 32'(bus.push_ready_o), 32'd0);
      if (bus.pop_valid_o && bus.pop_ready_i) begin
        check_val("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_val("pop_data", bus.pop_data_o, exp_q.pop_front());
      end
      if (bus.push_valid_i && bus.push_ready_o) begin
        check_val("wr_we", 32'(sram_we), 32'd1);
        check_val("wr_addr", 32'(sram_addr), 32'(wr_addr_m % DEPTH));
        check_val("wr_data", sram_wdata, bus.push_data_i);
        exp_q.push_back(bus.push_data_i);
        wr_addr_m++;
      end else begin
        check_val("idle_we", 32'(sram_we), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [31:0] base, input int limit);
    int acc = 0;
    int t = 0;
    while (acc < n && t < limit) begin
      bus.push_valid_i = 1'b1;
      bus.push_data_i  = base + 32'(acc);
      @(negedge clk);
      if (bus.push_ready_o) acc++;
      step();
      t++;
    end
    bus.push_valid_i = 1'b0;
    check_val("push_words_done", 32'(acc), 32'(n));
  endtask

  task automatic drain(input int limit);
    int k;
    bus.push_valid_i = 1'b0;
    bus.pop_ready_i  = 1'b1;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (empty && !bus.pop_valid_o) break;
      step();
    end
    check_val("drain_in_time", 32'(k < limit), 32'd1);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_push_ready"}, 32'(bus.push_ready_o), 32'd1);
    check_val({tag, "_pop_valid"},  32'(bus.pop_valid_o),  32'd0);
    check_val({tag, "_count"},      32'(count),            32'd0);
    check_val({tag, "_empty"},      32'(empty),            32'd1);
    check_val({tag, "_full"},       32'(full),             32'd0);
    check_val({tag, "_we"},         32'(sram_we),          32'd0);
    check_val({tag, "_addr"},       32'(sram_addr),        32'd0);
    check_val({tag, "_wdata"},      sram_wdata,            32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int k;
    int pc;
    int got;
    logic prev_we, prev_ready, prev_pv, seen_pop;
    int pv_pct, pr_pct;

    rst_n = 1'b0;
    bus.push_valid_i = 1'b0;
    bus.pop_ready_i  = 1'b0;
    bus.push_data_i  = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    // Single word latency: push in N, visible at the pop side in N+3, empty in N+4.
    bus.push_valid_i = 1'b1;
    bus.push_data_i  = 32'hA5A5_0001;
    bus.pop_ready_i  = 1'b1;
    @(negedge clk);
    check_val("single_we_n", 32'(sram_we), 32'd1);
    step();
    bus.push_valid_i = 1'b0;
    @(negedge clk);
    check_val("single_read_addr_n1", 32'(sram_addr), 32'd0);
    check_val("single_pv_n1", 32'(bus.pop_valid_o), 32'd0);
    step();
    @(negedge clk);
    check_val("single_pv_n2", 32'(bus.pop_valid_o), 32'd0);
    step();
    @(negedge clk);
    check_val("single_pv_n3", 32'(bus.pop_valid_o), 32'd1);
    check_val("single_data_n3", bus.pop_data_o, 32'hA5A5_0001);
    step();
    @(negedge clk);
    check_val("single_empty_n4", 32'(empty), 32'd1);
    check_val("single_pv_n4", 32'(bus.pop_valid_o), 32'd0);
    step();

    // Fill with pop stalled: capacity is DEPTH + OBUF_DEPTH.
    bus.pop_ready_i = 1'b0;
    acc = 0;
    for (int t = 0; t < 100; t++) begin
      bus.push_valid_i = 1'b1;
      bus.push_data_i  = 32'(acc);
      @(negedge clk);
      if (bus.push_ready_o) acc++;
      step();
    end
    @(negedge clk);
    check_val("fill_accepted", 32'(acc), 32'(DEPTH + OBUF_DEPTH));
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_ready", 32'(bus.push_ready_o), 32'd0);
    check_val("fill_count", 32'(count), 32'(DEPTH + OBUF_DEPTH));
    step();
    bus.push_valid_i = 1'b0;
    bus.pop_ready_i  = 1'b1;
    k = 0;
    for (int t = 0; t < 100 && k < DEPTH + OBUF_DEPTH; t++) begin
      @(negedge clk);
      if (bus.pop_valid_o) begin
        check_val("fill_pop_order", bus.pop_data_o, 32'(k));
        k++;
      end
      step();
    end
    check_val("fill_pops", 32'(k), 32'(DEPTH + OBUF_DEPTH));
    @(negedge clk);
    check_val("fill_empty", 32'(empty), 32'd1);
    step();

    // Bursts of ten across the pointer wrap.
    for (int b = 0; b < 4; b++) begin
      bus.pop_ready_i = 1'b0;
      push_words(10, 32'(100 + 10 * b), 50);
      drain(60);
    end
    @(negedge clk);
    check_val("wrap_count", 32'(count), 32'd0);
    step();

    // Contention: continuous push and pop.
    bus.push_valid_i = 1'b1;
    bus.pop_ready_i  = 1'b1;
    acc = 0;
    pc = 0;
    prev_we = 1'b0;
    prev_ready = 1'b1;
    prev_pv = 1'b0;
    seen_pop = 1'b0;
    for (int c = 0; c < 64; c++) begin
      bus.push_data_i = 32'(1000 + acc);
      @(negedge clk);
      if (c > 0) begin
        check_val("cont_we_alternates", 32'(sram_we), 32'(!prev_we));
        check_val("cont_push_stall", 32'(prev_ready | bus.push_ready_o), 32'd1);
        if (seen_pop) check_val("cont_pop_stall", 32'(prev_pv | bus.pop_valid_o), 32'd1);
      end
      if (bus.pop_valid_o) begin
        seen_pop = 1'b1;
        pc++;
      end
      if (bus.push_ready_o) acc++;
      prev_we = sram_we;
      prev_ready = bus.push_ready_o;
      prev_pv = bus.pop_valid_o;
      step();
    end
    check_val("cont_push_rate", 32'(acc >= 31), 32'd1);
    check_val("cont_pop_rate", 32'(pc >= 30), 32'd1);
    drain(40);

    // Random traffic in a few load regimes.
    for (int chunk = 0; chunk < 5; chunk++) begin
      pv_pct = $urandom_range(20, 95);
      pr_pct = $urandom_range(10, 95);
      for (int c = 0; c < 300; c++) begin
        bus.push_valid_i = ($urandom_range(0, 99) < pv_pct);
        bus.push_data_i  = $urandom;
        bus.pop_ready_i  = ($urandom_range(0, 99) < pr_pct);
        step();
      end
    end
    drain(100);

    // Mid-operation asynchronous reset with seven words queued.
    bus.pop_ready_i = 1'b0;
    push_words(7, 32'h7000, 40);
    @(negedge clk);
    check_val("midrst_count_before", 32'(count), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    bus.pop_ready_i = 1'b1;
    push_words(1, 32'h1, 20);
    got = 0;
    for (int t = 0; t < 20 && got == 0; t++) begin
      @(negedge clk);
      if (bus.pop_valid_o) begin
        check_val("midrst_pop_data", bus.pop_data_o, 32'h1);
        got = 1;
      end
      step();
    end
    check_val("midrst_pop_seen", 32'(got), 32'd1);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Controller that turns the single-port sram into a first-word-fall-through FIFO. It sits directly upstream of sram and drives its addr/wdata/we.
- Exposes valid/ready push and pop interfaces.
- Arbitrates the single SRAM port between writes and reads cycle by cycle.
- Hides the SRAM's 1-cycle read latency with a 3-entry output prefetch buffer.

Parameters:
- All constants come from fifo_package; there are no module-level parameters.
- DATA_WIDTH, 32, word width; must match sram.
- ADDR_WIDTH, 4, SRAM address width.
- DEPTH, 16, SRAM entries; DEPTH == 2**ADDR_WIDTH.
- OBUF_DEPTH, 3, prefetch buffer entries (new package constant).
- CNT_WIDTH, ADDR_WIDTH+2, width of the total-occupancy count (new package constant).

Ports:
- clk  input  1  clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- push_valid_i  input  1  producer has a word.
- push_ready_o  output  1  controller accepts; handshake = valid & ready.
- push_data_i  input  DATA_WIDTH  word to enqueue.
- pop_valid_o  output  1  head word available.
- pop_ready_i  input  1  consumer takes head.
- pop_data_o  output  DATA_WIDTH  head word.
- sram_addr_o  output  ADDR_WIDTH  to sram addr_i.
- sram_wdata_o  output  DATA_WIDTH  to sram wdata_i.
- sram_we_o  output  1  to sram we_i.
- sram_rdata_i  input  DATA_WIDTH  from sram rdata_o; valid the cycle after a read is issued.
- count_o  output  CNT_WIDTH  total words held: SRAM + in-flight + obuf.
- full_o  output  1  mem_cnt == DEPTH.
- empty_o  output  1  count_o == 0.

Behaviour:
- Reset values:
  - wr_ptr, rd_ptr, mem_cnt, ob_cnt, rd_inflight and wr_turn are all 0.
  - Outputs: push_ready_o=1, pop_valid_o=0, count_o=0, empty_o=1, full_o=0, sram_we_o=0.
  - sram_addr_o and sram_wdata_o are 0.
- Reset assertion mid-operation discards all queued data immediately. SRAM contents are not cleared.
- rd_want = (mem_cnt != 0) && (ob_cnt + rd_inflight < OBUF_DEPTH). It is computed from registers only.
- Arbitration:
  - rd_sched = rd_want && !(wr_turn && push_valid_i).
  - push_ready_o = !full_o && !(rd_want && !wr_turn). It never depends combinationally on push_valid_i.
  - wr_turn <= rd_sched, so priority alternates under contention and neither side starves.
- Write cycle (push handshake):
  - sram_we_o=1, sram_addr_o=wr_ptr, sram_wdata_o=push_data_i.
  - wr_ptr increments with natural wrap at DEPTH. mem_cnt increments.
- Read cycle (rd_sched):
  - sram_we_o=0, sram_addr_o=rd_ptr.
  - rd_ptr increments with wrap. mem_cnt decrements. rd_inflight <= 1.
- Idle cycle: sram_we_o=0, sram_addr_o holds rd_ptr.
- A write and a read never occur in the same cycle.
- Cycle after a read: sram_rdata_i is written into obuf at its tail.
- Obuf:
  - Circular buffer, OBUF_DEPTH entries.
  - pop_valid_o = ob_cnt != 0; pop_data_o = obuf head, taken straight from a register.
  - Pop handshake advances the head.
  - Simultaneous capture and pop in one cycle leaves ob_cnt unchanged.
- Latency: push accepted in cycle N (no contention) -> read in N+1 -> captured at end of N+2 -> pop_valid_o=1 in N+3.
- Capacity and full:
  - With pop stalled, up to DEPTH + OBUF_DEPTH words are accepted.
  - full_o asserts only when mem_cnt == DEPTH, forcing push_ready_o=0.
- Empty and blocking conditions:
  - Pop with empty obuf is impossible, since pop_valid_o=0.
  - Push while full is ignored, since ready=0.
- Throughput:
  - Pop-only streaming sustains 1 word/cycle.
  - Concurrent push+pop streaming sustains ≥1 word per 2 cycles on each side.
- count_o updates one cycle after each handshake. A push and a pop in the same cycle leave it unchanged.

Decomposition:
- fifo_package gains OBUF_DEPTH, CNT_WIDTH and an ob_ptr_t typedef. DATA_WIDTH, ADDR_WIDTH and DEPTH are reused from it.
- One sub-module, fifo_obuf: 3-entry prefetch register FIFO with wr_en/rd_en, data, and count output.
- Pointers and the arbiter stay in sram_fifo_ctrl.
- The top-level bench instantiates sram_fifo_ctrl plus sram.

Test Plan:
- Reset: hold rst_n=0 -> push_ready_o=1, pop_valid_o=0, empty_o=1, count_o=0, sram_we_o=0.
- Single word: push 0xA5A50001 in cycle N with pop_ready_i=1 -> sram_we_o=1 in N, read in N+1, pop_valid_o=1 with data 0xA5A50001 in N+3, empty_o=1 in N+4.
- Fill: pop_ready_i=0, push 0..99 continuously -> exactly 19 words accepted, full_o=1, push_ready_o=0, count_o=19. Then pop all -> data 0..18 in order, empty_o=1.
- Wrap: push and pop 40 incrementing words in bursts of 10 -> order preserved across pointer wrap at 16, count_o back to 0.
- Contention: push_valid_i=1 and pop_ready_i=1 continuously for 64 cycles -> sram_we_o alternates during contention, neither side stalls more than 1 cycle in 2, and popped sequence equals pushed sequence.
- Mid-operation reset: assert rst_n=0 asynchronously with 7 words queued -> outputs take reset values immediately. After release, push 0x1 -> pop returns 0x1, not stale data.
